// File: rtl/uart_tx_frame.sv
// uart_tx_frame: byte-wide valid/ready UART transmitter, LSB first, optional parity, 1 or 2 stop bits
module uart_tx_frame #(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);
    localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] LAST = 16'(CYCLE - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
    state_t state, next_state;
    logic [15:0] cnt;
    logic [2:0] idx;
    logic [7:0] shift;
    logic par_bit, pin_d, bit_end, accept, change;
    assign bit_end = cnt == LAST;
    assign accept = state == IDLE && tx_data_valid && tx_data_ready;
    assign change = next_state != state;
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            par_bit       <= 1'b0;
            tx_pin        <= 1'b1;
            tx_data_ready <= 1'b1;
        end else begin
            state         <= next_state;
            cnt           <= (state == IDLE || change || bit_end) ? '0 : cnt + 16'd1;
            idx           <= change ? '0 : bit_end ? idx + 3'd1 : idx;
            shift         <= accept ? tx_data : shift;
            par_bit       <= accept ? ((PARITY == 1) ? ~^tx_data : ^tx_data) : par_bit;
            tx_pin        <= pin_d;
            tx_data_ready <= next_state == IDLE;
        end
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? START : IDLE;
            START:   next_state = bit_end ? DATA : START;
            DATA:    next_state = (bit_end && idx == 3'd7) ? ((PARITY != 0) ? PAR : STOP) : DATA;
            PAR:     next_state = bit_end ? STOP : PAR;
            STOP:    next_state = (bit_end && idx == 3'(STOP_BITS - 1)) ? IDLE : STOP;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        pin_d = state == START ? 1'b0 :
                state == DATA  ? shift[idx] :
                state == PAR   ? par_bit : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed checks of uart_tx_frame across parity/stop-bit variants plus a loopback receiver
module tb_uart_tx_frame;
    localparam int C = 434;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] td [4];
    logic tv [4];
    logic rdy [4];
    logic pin [4];
    int total = 0;
    int bad = 0;
    logic rx_en = 1'b0;
    logic [7:0] rb;
    logic [7:0] rxq [$];

    always #10 clk = ~clk;

    uart_tx_frame d0 (.clk_50m(clk), .rst(rst), .tx_data(td[0]), .tx_data_valid(tv[0]), .tx_data_ready(rdy[0]), .tx_pin(pin[0]));
    uart_tx_frame #(.PARITY(2)) d1 (.clk_50m(clk), .rst(rst), .tx_data(td[1]), .tx_data_valid(tv[1]), .tx_data_ready(rdy[1]), .tx_pin(pin[1]));
    uart_tx_frame #(.PARITY(1)) d2 (.clk_50m(clk), .rst(rst), .tx_data(td[2]), .tx_data_valid(tv[2]), .tx_data_ready(rdy[2]), .tx_pin(pin[2]));
    uart_tx_frame #(.STOP_BITS(2)) d3 (.clk_50m(clk), .rst(rst), .tx_data(td[3]), .tx_data_valid(tv[3]), .tx_data_ready(rdy[3]), .tx_pin(pin[3]));

    always begin
        @(negedge pin[0]);
        repeat (C / 2) @(posedge clk);
        if (pin[0] == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(posedge clk);
                rb[i] = pin[0];
            end
            repeat (C) @(posedge clk);
            if (pin[0] && rx_en) rxq.push_back(rb);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int s, input logic [7:0] b, input logic hold);
        chk("ready_before_accept", 8'(rdy[s]), 8'd1);
        td[s] = b;
        tv[s] = 1'b1;
        step();
        chk("ready_low_after_accept", 8'(rdy[s]), 8'd0);
        chk("pin_high_on_accept_cycle", 8'(pin[s]), 8'd1);
        tv[s] = hold;
        td[s] = ~b;
    endtask

    task automatic frame(input int s, input logic [7:0] b, input int pm, input logic pexp, input int stops, input int inj);
        logic bits [12];
        int n;
        n = 0;
        bits[n++] = 1'b0;
        for (int i = 0; i < 8; i++) bits[n++] = b[i];
        if (pm != 0) bits[n++] = pexp;
        for (int i = 0; i < stops; i++) bits[n++] = 1'b1;
        for (int t = 1; t <= n * C; t++) begin
            step();
            if (inj != 0 && t == inj) begin
                td[s] = 8'hFF;
                tv[s] = 1'b1;
            end
            if (inj != 0 && t == inj + 1) tv[s] = 1'b0;
            if ((t - 1) % C == 0) chk($sformatf("dut%0d_bit%0d_first", s, (t - 1) / C), 8'(pin[s]), 8'(bits[(t - 1) / C]));
            if (t % C == 0) chk($sformatf("dut%0d_bit%0d_last", s, t / C - 1), 8'(pin[s]), 8'(bits[t / C - 1]));
            if (t == n * C - 1) chk("ready_low_at_frame_end", 8'(rdy[s]), 8'd0);
        end
        chk("ready_high_after_frame", 8'(rdy[s]), 8'd1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            td[i] = 8'h00;
            tv[i] = 1'b0;
        end
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            chk("reset_pin", 8'(pin[i]), 8'd1);
            chk("reset_ready", 8'(rdy[i]), 8'd1);
        end
        rst = 1'b0;
        step();

        send(0, 8'hA3, 1'b0);
        frame(0, 8'hA3, 0, 1'b0, 1, 0);

        send(1, 8'hA3, 1'b0);
        frame(1, 8'hA3, 2, 1'b0, 1, 0);
        send(1, 8'h07, 1'b0);
        frame(1, 8'h07, 2, 1'b1, 1, 0);
        send(2, 8'hA3, 1'b0);
        frame(2, 8'hA3, 1, 1'b1, 1, 0);

        send(3, 8'h55, 1'b1);
        td[3] = 8'h00;
        frame(3, 8'h55, 0, 1'b0, 2, 0);
        step();
        chk("b2b_extra_high_clock", 8'(pin[3]), 8'd1);
        chk("b2b_second_accept", 8'(rdy[3]), 8'd0);
        tv[3] = 1'b0;
        td[3] = 8'hC3;
        frame(3, 8'h00, 0, 1'b0, 2, 0);
        repeat (2 * C) step();
        chk("b2b_no_third_frame_pin", 8'(pin[3]), 8'd1);
        chk("b2b_no_third_frame_ready", 8'(rdy[3]), 8'd1);

        send(0, 8'h3C, 1'b0);
        frame(0, 8'h3C, 0, 1'b0, 1, 4 * C + 50);
        repeat (2 * C) step();
        chk("ignored_valid_pin_idle", 8'(pin[0]), 8'd1);
        chk("ignored_valid_ready", 8'(rdy[0]), 8'd1);

        send(0, 8'hA3, 1'b0);
        repeat (4 * C + 100) step();
        chk("data_bit3_before_reset", 8'(pin[0]), 8'd0);
        rst = 1'b1;
        step();
        chk("reset_abort_pin", 8'(pin[0]), 8'd1);
        chk("reset_abort_ready", 8'(rdy[0]), 8'd1);
        rst = 1'b0;
        repeat (C) step();
        chk("post_reset_pin", 8'(pin[0]), 8'd1);
        chk("post_reset_ready", 8'(rdy[0]), 8'd1);
        send(0, 8'h5A, 1'b0);
        frame(0, 8'h5A, 0, 1'b0, 1, 0);

        repeat (12 * C) step();
        rxq.delete();
        rx_en = 1'b1;
        send(0, 8'hA3, 1'b1);
        td[0] = 8'h00;
        for (int w = 0; w < 12 * C && !(rdy[0] && tv[0] && $time > 0 && d0.state != d0.IDLE); w++) begin
            step();
            if (rdy[0]) break;
        end
        step();
        td[0] = 8'hFF;
        for (int w = 0; w < 12 * C; w++) begin
            step();
            if (rdy[0]) break;
        end
        step();
        tv[0] = 1'b0;
        for (int w = 0; w < 14 * C && rxq.size() < 3; w++) step();
        chk("loopback_count", 8'(rxq.size()), 8'd3);
        if (rxq.size() == 3) begin
            chk("loopback_byte0", rxq[0], 8'hA3);
            chk("loopback_byte1", rxq[1], 8'h00);
            chk("loopback_byte2", rxq[2], 8'hFF);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
